// File: rtl/dt1_pkg.sv
// dt1_pkg: shared definitions for the dt1 decode stage.
//   - RV32I base opcodes
//   - ALU operation codes driven on ALUControlE
//   - ResultSrc / ALUSrcA encodings
//   - immediate-type codes and the immediate extender
//   - funct3/funct7 to ALU operation mapping
package dt1_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluOp_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrc_t;

    typedef enum logic [1:0] {
        SRCA_RD1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } srcA_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } immType_t;

    function automatic logic [31:0] extendImm(input logic [31:0] i, input immType_t t);
        logic [31:0] imm;
        case (t)
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            default: imm = {{20{i[31]}}, i[31:20]};
        endcase
        return imm;
    endfunction

    // alt selects SUB over ADD and SRA over SRL; it is ignored for every
    // other funct3 so stray funct7 bits cannot change the operation.
    function automatic aluOp_t aluFromFunct(input logic [2:0] f3, input logic alt);
        aluOp_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dt1_regfile.sv
// dt1_regfile: 32x32 register file, two combinational read ports, one
// synchronous write port with write-through bypass.
//   clk, rst         clock, synchronous active-high reset (clears all entries)
//   ra1, ra2         read addresses
//   rd1, rd2         read data (x0 reads 0; a same-cycle write is forwarded)
//   we, wa, wd       write enable / address / data (writes to x0 dropped)
module dt1_regfile
    import dt1_pkg::*;
#(
    parameter int NR = NREGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [NR];
    logic        wrLive;

    assign wrLive = we && (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                regs[k] <= '0;
            end
        end else if (wrLive) begin
            regs[wa] <= wd;
        end
    end

    // Forwarding the writeback value here resolves the WB-to-ID hazard
    // without splitting the write onto the opposite clock edge.
    function automatic logic [31:0] readPort(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0)                v = '0;
        else if (wrLive && (wa == a)) v = wd;
        else                          v = regs[a];
        return v;
    endfunction

    assign rd1 = readPort(ra1);
    assign rd2 = readPort(ra2);

endmodule

// File: rtl/dt1_id_stage.sv
// dt1_id_stage: decode stage of the 5-stage RV32I pipeline.
// Decodes InstrD, reads the register file and registers everything into the
// ID/EX pipeline register (1-cycle latency).
//   clk, rst                    clock, synchronous active-high reset
//   InstrD, PCD, PCPlus4D       instruction and PCs from IF/ID
//   FlushE                      load an all-zero bubble into ID/EX
//   RegWriteW, RdW, ResultW     writeback port into the register file
//   Rs1D, Rs2D                  combinational source fields for the hazard unit
//   *E                          ID/EX register outputs for execute
module dt1_id_stage
    import dt1_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN_P-1:0] PCD,
    input  logic [XLEN_P-1:0] PCPlus4D,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [4:0]        RdW,
    input  logic [XLEN_P-1:0] ResultW,
    output logic [4:0]        Rs1D,
    output logic [4:0]        Rs2D,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              MemReadE,
    output logic              JumpE,
    output logic              JalrE,
    output logic              BranchE,
    output logic [3:0]        ALUControlE,
    output logic [1:0]        ALUSrcAE,
    output logic              ALUSrcBE,
    output logic [2:0]        Funct3E,
    output logic              IllegalE,
    output logic [XLEN_P-1:0] RD1E,
    output logic [XLEN_P-1:0] RD2E,
    output logic [XLEN_P-1:0] ImmExtE,
    output logic [XLEN_P-1:0] PCE,
    output logic [XLEN_P-1:0] PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rd1D, rd2D;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    dt1_regfile #(.NR(NREGS_P)) uRegfile (
        .clk (clk),
        .rst (rst),
        .ra1 (Rs1D),
        .ra2 (Rs2D),
        .rd1 (rd1D),
        .rd2 (rd2D),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW)
    );

    logic       regWriteD, memWriteD, memReadD, jumpD, jalrD, branchD;
    logic       aluSrcBD, illegalD;
    resultSrc_t resultSrcD;
    srcA_t      aluSrcAD;
    aluOp_t     aluControlD;
    immType_t   immTypeD;

    always_comb begin
        regWriteD   = 1'b0;
        memWriteD   = 1'b0;
        memReadD    = 1'b0;
        jumpD       = 1'b0;
        jalrD       = 1'b0;
        branchD     = 1'b0;
        aluSrcBD    = 1'b0;
        illegalD    = 1'b0;
        resultSrcD  = RES_ALU;
        aluSrcAD    = SRCA_RD1;
        aluControlD = ALU_ADD;
        immTypeD    = IMM_I;
        case (opcode)
            OPC_OP: begin
                regWriteD   = 1'b1;
                aluControlD = aluFromFunct(funct3, InstrD[30]);
            end
            OPC_OPIMM: begin
                // funct7[5] is part of the immediate except for SRAI.
                regWriteD   = 1'b1;
                aluSrcBD    = 1'b1;
                aluControlD = aluFromFunct(funct3, InstrD[30] && (funct3 == 3'b101));
            end
            OPC_LOAD: begin
                regWriteD  = 1'b1;
                memReadD   = 1'b1;
                resultSrcD = RES_MEM;
                aluSrcBD   = 1'b1;
            end
            OPC_STORE: begin
                memWriteD = 1'b1;
                aluSrcBD  = 1'b1;
                immTypeD  = IMM_S;
            end
            OPC_BRANCH: begin
                branchD     = 1'b1;
                aluControlD = ALU_SUB;
                immTypeD    = IMM_B;
            end
            OPC_JAL: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                resultSrcD = RES_PC4;
                immTypeD   = IMM_J;
            end
            OPC_JALR: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                jalrD      = 1'b1;
                resultSrcD = RES_PC4;
                aluSrcBD   = 1'b1;
            end
            OPC_LUI: begin
                aluSrcAD = SRCA_ZERO;
                aluSrcBD = 1'b1;
                immTypeD = IMM_U;
            end
            OPC_AUIPC: begin
                aluSrcAD = SRCA_PC;
                aluSrcBD = 1'b1;
                immTypeD = IMM_U;
            end
            default: begin
                // An all-zero word is the bubble pattern and must not trap.
                illegalD = (InstrD != 32'd0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            JumpE       <= 1'b0;
            JalrE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcAE    <= '0;
            ALUSrcBE    <= 1'b0;
            Funct3E     <= '0;
            IllegalE    <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else begin
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            MemReadE    <= memReadD;
            JumpE       <= jumpD;
            JalrE       <= jalrD;
            BranchE     <= branchD;
            ALUControlE <= aluControlD;
            ALUSrcAE    <= aluSrcAD;
            ALUSrcBE    <= aluSrcBD;
            Funct3E     <= funct3;
            IllegalE    <= illegalD;
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= extendImm(InstrD, immTypeD);
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= InstrD[11:7];
        end
    end

endmodule

// File: tb/tb_dt1_id_stage.sv
module tb_dt1_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, MemReadE, JumpE, JalrE, BranchE, ALUSrcBE, IllegalE;
    logic [1:0]  ResultSrcE, ALUSrcAE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

    always #5 clk = ~clk;

    dt1_id_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .MemReadE(MemReadE), .JumpE(JumpE), .JalrE(JalrE),
        .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
        .ALUSrcBE(ALUSrcBE), .Funct3E(Funct3E), .IllegalE(IllegalE), .RD1E(RD1E),
        .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resSrc;
        logic        memWrite;
        logic        memRead;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic [3:0]  alu;
        logic [1:0]  srcA;
        logic        srcB;
        logic        illegal;
        logic [31:0] imm;
    } exp_t;

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] mregs [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ALU number for funct3, with alt adding one to reach SUB / SRA.
    function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic alt);
        int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int n;
        n = base[f3];
        if (alt && (f3 == 3'd0 || f3 == 3'd5)) n = n + 1;
        return 4'(n);
    endfunction

    function automatic exp_t decode(input logic [31:0] i);
        exp_t e;
        logic [2:0] f3;
        f3 = i[14:12];
        e = '0;
        e.imm = 32'($signed(i[31:20]));
        case (i[6:0])
            7'h33: begin e.regWrite = 1; e.alu = aluFor(f3, i[30]); end
            7'h13: begin e.regWrite = 1; e.srcB = 1; e.alu = aluFor(f3, i[30] && f3 == 3'd5); end
            7'h03: begin e.regWrite = 1; e.memRead = 1; e.resSrc = 1; e.srcB = 1; end
            7'h23: begin e.memWrite = 1; e.srcB = 1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h63: begin
                e.branch = 1; e.alu = 1;
                e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h6F: begin
                e.regWrite = 1; e.jump = 1; e.resSrc = 2;
                e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'h67: begin e.regWrite = 1; e.jump = 1; e.jalr = 1; e.resSrc = 2; e.srcB = 1; end
            7'h37: begin e.srcA = 2; e.srcB = 1; e.imm = i & 32'hFFFFF000; end
            7'h17: begin e.srcA = 1; e.srcB = 1; e.imm = i & 32'hFFFFF000; end
            default: e.illegal = (i != 0);
        endcase
        return e;
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] a, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    // One pipeline cycle: drive, check hazard-unit taps, clock, check ID/EX.
    task automatic step(input logic r, input logic [31:0] instr, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic [31:0] pc, v1, v2, pc4;
        logic [4:0] s1, s2, d;
        logic [2:0] f3;
        pc = $urandom & 32'hFFFFFFFC;
        rst = r; InstrD = instr; PCD = pc; PCPlus4D = pc + 4;
        FlushE = fl; RegWriteW = we; RdW = wa; ResultW = wd;
        #1;
        chk("Rs1D", 32'(Rs1D), 32'(instr[19:15]));
        chk("Rs2D", 32'(Rs2D), 32'(instr[24:20]));
        e = decode(instr);
        v1 = readModel(instr[19:15], we, wa, wd);
        v2 = readModel(instr[24:20], we, wa, wd);
        s1 = instr[19:15]; s2 = instr[24:20]; d = instr[11:7]; f3 = instr[14:12];
        pc4 = pc + 4;
        if (r || fl) begin
            e = '0; v1 = 0; v2 = 0; s1 = 0; s2 = 0; d = 0; f3 = 0; pc = 0; pc4 = 0;
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 32; k++) mregs[k] = 0;
        end else if (we && wa != 0) begin
            mregs[wa] = wd;
        end
        chk("RegWriteE", 32'(RegWriteE), 32'(e.regWrite));
        chk("ResultSrcE", 32'(ResultSrcE), 32'(e.resSrc));
        chk("MemWriteE", 32'(MemWriteE), 32'(e.memWrite));
        chk("MemReadE", 32'(MemReadE), 32'(e.memRead));
        chk("JumpE", 32'(JumpE), 32'(e.jump));
        chk("JalrE", 32'(JalrE), 32'(e.jalr));
        chk("BranchE", 32'(BranchE), 32'(e.branch));
        chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        chk("ALUSrcAE", 32'(ALUSrcAE), 32'(e.srcA));
        chk("ALUSrcBE", 32'(ALUSrcBE), 32'(e.srcB));
        chk("Funct3E", 32'(Funct3E), 32'(f3));
        chk("IllegalE", 32'(IllegalE), 32'(e.illegal));
        chk("RD1E", RD1E, v1);
        chk("RD2E", RD2E, v2);
        chk("ImmExtE", ImmExtE, e.imm);
        chk("PCE", PCE, pc);
        chk("PCPlus4E", PCPlus4E, pc4);
        chk("Rs1E", 32'(Rs1E), 32'(s1));
        chk("Rs2E", 32'(Rs2E), 32'(s2));
        chk("RdE", 32'(RdE), 32'(d));
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h7F, 7'h00};
        logic [31:0] w;
        int sel;
        sel = $urandom_range(0, 11);
        w = $urandom;
        if (sel == 11) return 32'd0;
        return {w[31:7], ops[sel]};
    endfunction

    initial begin
        for (int k = 0; k < 32; k++) mregs[k] = 0;

        // Reset for two cycles with a live ADDI on the input.
        step(1, 32'h00500093, 0, 0, 0, 0);
        step(1, 32'h00500093, 0, 0, 0, 0);
        chk("reset_RegWriteE", 32'(RegWriteE), 0);
        chk("reset_ImmExtE", ImmExtE, 0);
        for (int k = 1; k < 32; k++) begin
            step(0, {7'd0, 5'(k), 5'(k), 3'd0, 5'd0, 7'h33}, 0, 0, 0, 0);
            chk("reset_reg_read", RD1E, 0);
        end

        // addi x1,x0,5
        step(0, 32'h00500093, 0, 0, 0, 0);
        chk("addi_RegWriteE", 32'(RegWriteE), 1);
        chk("addi_ALUSrcBE", 32'(ALUSrcBE), 1);
        chk("addi_ImmExtE", ImmExtE, 5);
        chk("addi_RdE", 32'(RdE), 1);
        chk("addi_ALUControlE", 32'(ALUControlE), 0);

        // Write-through bypass into add x2,x2,x2, then x0 write ignored.
        step(0, 32'h00210133, 0, 1, 2, 32'hDEADBEEF);
        chk("bypass_RD1E", RD1E, 32'hDEADBEEF);
        chk("bypass_RD2E", RD2E, 32'hDEADBEEF);
        step(0, 32'h000001B3, 0, 1, 0, 32'hDEADBEEF);
        chk("x0_bypass_RD1E", RD1E, 0);
        step(0, 32'h00010033, 0, 0, 0, 0);
        chk("x2_stored_RD1E", RD1E, 32'hDEADBEEF);

        // Immediates.
        step(0, 32'hFE50AE23, 0, 0, 0, 0);
        chk("sw_ImmExtE", ImmExtE, 32'hFFFFFFFC);
        chk("sw_MemWriteE", 32'(MemWriteE), 1);
        step(0, 32'hFE000CE3, 0, 0, 0, 0);
        chk("beq_ImmExtE", ImmExtE, 32'hFFFFFFF8);
        chk("beq_BranchE", 32'(BranchE), 1);
        step(0, 32'h001000EF, 0, 0, 0, 0);
        chk("jal_ImmExtE", ImmExtE, 32'h00000800);
        chk("jal_JumpE", 32'(JumpE), 1);
        chk("jal_ResultSrcE", 32'(ResultSrcE), 2);

        // Flush beats a valid load, then the load goes through.
        step(0, 32'h0000A103, 1, 0, 0, 0);
        chk("flush_MemReadE", 32'(MemReadE), 0);
        chk("flush_RdE", 32'(RdE), 0);
        step(0, 32'h0000A103, 0, 0, 0, 0);
        chk("lw_MemReadE", 32'(MemReadE), 1);
        chk("lw_ResultSrcE", 32'(ResultSrcE), 1);
        chk("lw_RdE", 32'(RdE), 2);

        // Illegal opcode, zero bubble, LUI.
        step(0, 32'h0000007F, 0, 0, 0, 0);
        chk("illegal_IllegalE", 32'(IllegalE), 1);
        chk("illegal_RegWriteE", 32'(RegWriteE), 0);
        chk("illegal_MemWriteE", 32'(MemWriteE), 0);
        step(0, 32'h00000000, 0, 0, 0, 0);
        chk("zero_IllegalE", 32'(IllegalE), 0);
        step(0, 32'h123451B7, 0, 0, 0, 0);
        chk("lui_ImmExtE", ImmExtE, 32'h12345000);
        chk("lui_ALUSrcAE", 32'(ALUSrcAE), 2);

        // Reset wins over a simultaneous write.
        step(0, 32'h00000013, 0, 1, 5, 32'h00000055);
        step(1, 32'h00000013, 0, 1, 5, 32'h00001234);
        step(0, 32'h00028033, 0, 0, 0, 0);
        chk("reset_wins_RD1E", RD1E, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) == 0), randInstr(), ($urandom_range(0, 9) == 0),
                 1'($urandom), 5'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dt1_id_stage.md
Name: dt1_id_stage

Overview:
Decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID register and the execute stage.
- Decodes InstrD into control signals and a sign-extended immediate.
- Holds the 32x32 register file: two read ports, one write port from writeback.
- Registers everything into the ID/EX pipeline register for execute.
- Exposes Rs1D/Rs2D combinationally so the hazard unit can detect load-use stalls.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- InstrD  in  32  instruction from the IF/ID register
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- FlushE  in  1  hazard unit: load a bubble into ID/EX
- RegWriteW  in  1  writeback register-file write enable
- RdW  in  5  writeback destination register
- ResultW  in  32  writeback data
- Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
- Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
- RegWriteE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1  store
- MemReadE  out  1  load (used by the hazard unit)
- JumpE  out  1  JAL or JALR
- JalrE  out  1  JALR (target = RD1+Imm)
- BranchE  out  1  conditional branch
- ALUControlE  out  4  ALU operation code from the package
- ALUSrcAE  out  2  00 RD1, 01 PC, 10 zero
- ALUSrcBE  out  1  0 RD2, 1 ImmExt
- Funct3E  out  3  branch condition / load-store width
- IllegalE  out  1  unsupported opcode
- RD1E  out  32  register data
- RD2E  out  32  register data
- ImmExtE  out  32  extended immediate
- PCE  out  32  PC of the instruction now in execute
- PCPlus4E  out  32  PC+4 of the instruction now in execute
- Rs1E  out  5  source register
- Rs2E  out  5  source register
- RdE  out  5  destination register

Behaviour:
- Latency: 1 cycle. A value on InstrD before posedge n appears on the *E outputs after posedge n.

ID/EX register priority, per posedge:
- rst, then FlushE: all *E outputs go to 0. This all-zero state is a NOP bubble: no write, no memory access, no jump.
- Otherwise every *E output loads. There is no stall input; the hazard unit stalls IF/ID and flushes E instead.
- Reset value of every registered output is 0.

Register file:
- All 32 entries clear to 0 on rst.
- Write on posedge when RegWriteW=1 and RdW!=0. Writes to x0 are ignored.
- Reads are combinational. x0 always reads 0.
- Write-through bypass: if RegWriteW=1 and RdW!=0 and RdW equals the read address, the port returns ResultW in that same cycle. This covers WB-to-ID hazards without a half-cycle clock.
- rst and a pending write in the same cycle: reset wins.

Immediate types, selected by opcode:
- I: {20{i[31]}, i[31:20]}
- S: {20{i[31]}, i[31:25], i[11:7]}
- B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
- J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- U: {i[31:12], 12'b0}

Decode by opcode:
- OP: RegWrite. ALU op from funct3 with funct7[5] selecting SUB/SRA.
- OP-IMM: RegWrite, SrcB=imm. funct7[5] is honoured only for SRAI.
- LOAD: RegWrite, MemRead, ResultSrc=01, ALU ADD, SrcB=imm.
- STORE: MemWrite, ALU ADD, SrcB=imm, S-imm.
- BRANCH: Branch, ALU SUB, SrcB=RD2, B-imm.
- JAL: RegWrite, Jump, ResultSrc=10, J-imm.
- JALR: RegWrite, Jump, Jalr, ResultSrc=10, ALU ADD, SrcB=imm.
- LUI: SrcA=zero, SrcB=imm, ADD, U-imm.
- AUIPC: SrcA=PC, SrcB=imm, ADD, U-imm.
- Any other opcode (all-zero InstrD included): every enable is 0, IllegalE=1, except that all-zero InstrD gives IllegalE=0 so flushed bubbles stay silent.

Decomposition:
- Package dt1_pkg holds:
  - opcode localparams;
  - ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9;
  - ResultSrc and ALUSrcA encodings;
  - immediate-type codes.
- Sub-module dt1_regfile: register file with bypass.
- Decoder and immediate extender stay inline.

Test Plan:
- Reset: assert rst 2 cycles with InstrD=0x00500093 -> all *E outputs 0; x1..x31 read 0.
- ADDI: InstrD=0x00500093 (addi x1,x0,5) -> next cycle RegWriteE=1, ALUSrcBE=1, ImmExtE=5, RdE=1, ALUControlE=ADD.
- Bypass: RegWriteW=1, RdW=2, ResultW=0xDEADBEEF, with InstrD=0x00210133 (add x2,x2,x2) in the same cycle -> RD1E=RD2E=0xDEADBEEF after the edge. The same write with RdW=0 -> x0 still reads 0.
- Immediates:
  - sw x5,-4(x1) = 0xFE50AE23 -> ImmExtE=0xFFFFFFFC, MemWriteE=1.
  - beq x0,x0,-8 = 0xFE000CE3 -> ImmExtE=0xFFFFFFF8, BranchE=1.
  - jal x1,2048 = 0x001000EF -> ImmExtE=0x800, JumpE=1, ResultSrcE=10.
- Flush priority: valid lw (0x0000A103) with FlushE=1 -> all *E outputs 0. Next cycle with FlushE=0 -> MemReadE=1, ResultSrcE=01, RdE=2.
- Illegal/LUI:
  - InstrD=0x0000007F -> IllegalE=1, RegWriteE=0, MemWriteE=0.
  - lui x3,0x12345 = 0x123451B7 -> ImmExtE=0x12345000, ALUSrcAE=10.
